// File: rtl/multicycle_control_if.sv
// multicycle_control_if: instruction-register inputs and datapath strobes of the multicycle control unit
interface multicycle_control_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic             mem_ready;
    logic             pc_write;
    logic             pc_write_cond_eq;
    logic             pc_write_cond_ne;
    logic             iord;
    logic             mem_read;
    logic             mem_write;
    logic             ir_write;
    logic             mem_to_reg;
    logic             reg_dst;
    logic             reg_write;
    logic             link;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       alu_op;
    logic [1:0]       pc_source;
    logic [3:0]       state;
    logic             instr_done;
    logic [CNT_W-1:0] retired;
    logic             illegal;

    modport master (
        input  opcode, funct, mem_ready,
        output pc_write, pc_write_cond_eq, pc_write_cond_ne, iord, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, link, alu_src_a, alu_src_b, alu_op, pc_source,
               state, instr_done, retired, illegal
    );

    modport slave (
        output opcode, funct, mem_ready,
        input  pc_write, pc_write_cond_eq, pc_write_cond_ne, iord, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, link, alu_src_a, alu_src_b, alu_op, pc_source,
               state, instr_done, retired, illegal
    );
endinterface

// File: rtl/multicycle_control.sv
// multicycle_control: Moore FSM sequencing multicycle MIPS instructions; define MULTICYCLE_CONTROL_TRAP_EN to trap illegal opcodes/functs
module multicycle_control #(
    parameter int MEM_HS  = 1,
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 32
) (
    input logic                  clk,
    input logic                  rst_n,
    multicycle_control_if.master bus
);
`ifdef MULTICYCLE_CONTROL_TRAP_EN
    localparam logic TRAP_EN = 1'b1;
`else
    localparam logic TRAP_EN = 1'b0;
`endif
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [3:0] LAT_LAST = 4'(MEM_LAT - 1);

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        R_EXEC    = 4'd6,
        R_WB      = 4'd7,
        BRANCH    = 4'd8,
        JUMP      = 4'd9,
        ADDI_EX   = 4'd10,
        ADDI_WB   = 4'd11,
        JAL       = 4'd12,
        JR        = 4'd13,
        TRAP      = 4'd14
    } state_t;

    state_t           state, state_n;
    logic [3:0]       wait_cnt;
    logic [CNT_W-1:0] retired;
    logic             done, funct_ok, instr_done;
    logic             pc_write, pc_write_cond_eq, pc_write_cond_ne, iord, mem_read, mem_write, ir_write;
    logic             mem_to_reg, reg_dst, reg_write, link, alu_src_a;
    logic [1:0]       alu_src_b, alu_op, pc_source;

    assign done     = (MEM_HS != 0) ? bus.mem_ready : (wait_cnt == LAT_LAST);
    assign funct_ok = bus.funct inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, FN_JR};

    // State register; reset aborts any instruction in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= FETCH;
        else        state <= state_n;
    end

    // Wait counter restarts on every state change so each memory state times from zero; retired counts completions
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
            retired  <= '0;
        end else begin
            wait_cnt <= (state_n == state) ? wait_cnt + 4'd1 : 4'd0;
            retired  <= retired + CNT_W'(instr_done);
        end
    end

    // Next-state and Moore output decode; only done gating and opcode selects look at inputs
    always_comb begin
        state_n          = state;
        pc_write         = 1'b0;
        pc_write_cond_eq = 1'b0;
        pc_write_cond_ne = 1'b0;
        iord             = 1'b0;
        mem_read         = 1'b0;
        mem_write        = 1'b0;
        ir_write         = 1'b0;
        mem_to_reg       = 1'b0;
        reg_dst          = 1'b0;
        reg_write        = 1'b0;
        link             = 1'b0;
        alu_src_a        = 1'b0;
        alu_src_b        = 2'b00;
        alu_op           = 2'b00;
        pc_source        = 2'b00;
        instr_done       = 1'b0;
        case (state)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = done;
                pc_write  = done;
                state_n   = done ? DECODE : FETCH;
            end
            DECODE: begin
                alu_src_b = 2'b11;
                case (bus.opcode)
                    OP_LW, OP_SW:   state_n = MEM_ADDR;
                    OP_RTYPE:       state_n = (bus.funct == FN_JR) ? JR : (TRAP_EN && !funct_ok) ? TRAP : R_EXEC;
                    OP_ADDI:        state_n = ADDI_EX;
                    OP_BEQ, OP_BNE: state_n = BRANCH;
                    OP_J:           state_n = JUMP;
                    OP_JAL:         state_n = JAL;
                    default: begin
                        state_n    = TRAP_EN ? TRAP : FETCH;
                        instr_done = !TRAP_EN;
                    end
                endcase
            end
            MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_n   = (bus.opcode == OP_SW) ? MEM_WRITE : MEM_READ;
            end
            MEM_READ: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                state_n  = done ? MEM_WB : MEM_READ;
            end
            MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
                state_n    = FETCH;
            end
            MEM_WRITE: begin
                mem_write  = 1'b1;
                iord       = 1'b1;
                instr_done = done;
                state_n    = done ? FETCH : MEM_WRITE;
            end
            R_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                state_n   = R_WB;
            end
            R_WB: begin
                reg_dst    = 1'b1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_n    = FETCH;
            end
            ADDI_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_n   = ADDI_WB;
            end
            ADDI_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_n    = FETCH;
            end
            BRANCH: begin
                alu_src_a        = 1'b1;
                alu_op           = 2'b01;
                pc_source        = 2'b01;
                pc_write_cond_eq = (bus.opcode == OP_BEQ);
                pc_write_cond_ne = (bus.opcode == OP_BNE);
                instr_done       = 1'b1;
                state_n          = FETCH;
            end
            JUMP: begin
                pc_write   = 1'b1;
                pc_source  = 2'b10;
                instr_done = 1'b1;
                state_n    = FETCH;
            end
            JAL: begin
                pc_write   = 1'b1;
                pc_source  = 2'b10;
                reg_write  = 1'b1;
                link       = 1'b1;
                instr_done = 1'b1;
                state_n    = FETCH;
            end
            JR: begin
                pc_write   = 1'b1;
                pc_source  = 2'b11;
                instr_done = 1'b1;
                state_n    = FETCH;
            end
            TRAP:    state_n = TRAP;
            default: state_n = FETCH;
        endcase
    end

    // Everything the datapath sees is held at zero while reset is asserted
    assign {bus.pc_write, bus.pc_write_cond_eq, bus.pc_write_cond_ne, bus.iord, bus.mem_read, bus.mem_write,
            bus.ir_write, bus.mem_to_reg, bus.reg_dst, bus.reg_write, bus.link, bus.alu_src_a, bus.alu_src_b,
            bus.alu_op, bus.pc_source, bus.state, bus.instr_done, bus.illegal} =
        rst_n ? {pc_write, pc_write_cond_eq, pc_write_cond_ne, iord, mem_read, mem_write,
                 ir_write, mem_to_reg, reg_dst, reg_write, link, alu_src_a, alu_src_b,
                 alu_op, pc_source, state, instr_done, TRAP_EN && (state == TRAP)} : '0;
    assign bus.retired = retired;
endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multicycle MIPS control unit: a Moore state machine that sequences each instruction over 3–5 cycles and drives the shared-memory/ALU/register-file datapath strobes. It sits between the instruction register (opcode/funct) and the multicycle datapath. Compared with the single-cycle decoder, it adds:
- memory-handshake stalls (or fixed-latency waits);
- correct `jr` decode via funct;
- a retired-instruction counter;
- an optional illegal-opcode trap.

## Interface
- `MEM_HS`, 1 — 1: memory states wait for `mem_ready`; 0: fixed latency of `MEM_LAT` cycles from an internal counter.
- `MEM_LAT`, 1 — cycles per memory access when `MEM_HS`=0; legal range 1–15.
- `CNT_W`, 32 — width of `retired`.
- `clk` in 1 — clock; all state changes on the rising edge.
- `rst_n` in 1 — asynchronous, active-low reset.
- `opcode` in 6 — IR[31:26].
- `funct` in 6 — IR[5:0].
- `mem_ready` in 1 — memory access complete; ignored when `MEM_HS`=0.
- `pc_write`, `pc_write_cond_eq`, `pc_write_cond_ne` out 1 each — PC update strobes.
- `iord` out 1 — 0: memory address from PC; 1: address from ALUOut.
- `mem_read`, `mem_write`, `ir_write` out 1 each — memory and IR strobes.
- `mem_to_reg`, `reg_dst`, `reg_write`, `link` out 1 each — register-file controls; `link` writes PC to $31.
- `alu_src_a` out 1, `alu_src_b` out 2, `alu_op` out 2 — ALU controls.
- `pc_source` out 2 — 00 ALU, 01 ALUOut, 10 jump target, 11 rs.
- `state` out 4 — current state (debug).
- `instr_done` out 1 — one-cycle pulse on the last cycle of an instruction.
- `retired` out `CNT_W` — count of completed instructions.
- `illegal` out 1 — trap flag.

## Operation
- States and encodings: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, R_EXEC 6, R_WB 7, BRANCH 8, JUMP 9, ADDI_EX 10, ADDI_WB 11, JAL 12, JR 13, TRAP 14.
- Any output not listed for a state is 0.
- Memory-done signal `done`:
  - `MEM_HS`=1: `done` = `mem_ready`.
  - `MEM_HS`=0: `done` when the wait counter equals `MEM_LAT`-1. The counter clears on entry to every memory state.
- FETCH:
  - Outputs: `mem_read`=1, `alu_src_b`=01, `alu_op`=00.
  - `ir_write` and `pc_write` are asserted only when `done`.
  - Next state: DECODE on `done`, otherwise hold.
- DECODE:
  - Outputs: `alu_src_b`=11, `alu_op`=00.
  - Dispatch by opcode:
    - lw 100011 and sw 101011 → MEM_ADDR.
    - 000000 with funct 001000 → JR; other funct → R_EXEC.
    - addi 001000 → ADDI_EX.
    - beq 000100 and bne 000101 → BRANCH.
    - j 000010 → JUMP.
    - jal 000011 → JAL.
    - Any other opcode → see Configuration.
- MEM_ADDR:
  - Outputs: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00.
  - Next state: MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ: `mem_read`=1, `iord`=1; next MEM_WB on `done`, otherwise hold.
- MEM_WB: `reg_write`=1, `mem_to_reg`=1.
- MEM_WRITE: `mem_write`=1, `iord`=1; next FETCH on `done`, otherwise hold.
- R_EXEC: `alu_src_a`=1, `alu_op`=10; next R_WB.
- R_WB: `reg_dst`=1, `reg_write`=1.
- ADDI_EX: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00; next ADDI_WB.
- ADDI_WB: `reg_write`=1.
- BRANCH: `alu_src_a`=1, `alu_op`=01, `pc_source`=01; `pc_write_cond_eq` for beq, `pc_write_cond_ne` for bne.
- JUMP: `pc_write`=1, `pc_source`=10.
- JAL: `pc_write`=1, `pc_source`=10, `reg_write`=1, `link`=1.
- JR: `pc_write`=1, `pc_source`=11.
- Return to FETCH: MEM_WB, R_WB, ADDI_WB, BRANCH, JUMP, JAL and JR go to FETCH next. Each of these, plus MEM_WRITE when `done`, asserts `instr_done` for its final cycle.
- `retired` increments on every `instr_done` and wraps modulo 2^`CNT_W`.

## Timing
- All control outputs are combinational decodes of the state register (Moore); there is no decode of inputs into outputs except `done` gating and the opcode selects noted above.
- Reset:
  - While `rst_n`=0, all outputs are forced to 0, state = FETCH, wait counter = 0, `retired` = 0, `illegal` = 0.
  - Asserting reset mid-instruction aborts the instruction immediately.
  - After release, the first rising edge sees FETCH.
- Cycle counts with zero stalls (`MEM_HS`=1 with `mem_ready`=1, or `MEM_LAT`=1):
  - lw: 5; sw: 4; R-type and addi: 4; beq, bne, j, jal, jr: 3.
  - With `MEM_HS`=0, each memory state lasts `MEM_LAT` cycles.
- Under `MEM_HS`=1, a `mem_ready` pulse outside FETCH, MEM_READ and MEM_WRITE is ignored.

## Configuration
- `MULTICYCLE_CONTROL_TRAP_EN` defined:
  - An undefined opcode, or an R-type funct outside the supported set, goes DECODE → TRAP.
  - TRAP holds with all strobes 0 and `illegal`=1 until reset; no `instr_done`.
  - Supported R-type funct set: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt, 001000 jr.
- `MULTICYCLE_CONTROL_TRAP_EN` undefined:
  - An undefined opcode goes DECODE → FETCH with `instr_done`=1 (treated as NOP).
  - Every R-type funct other than 001000 executes via R_EXEC.
  - `illegal` is tied to 0 and TRAP is unreachable.

## Test plan
- Reset release, then lw (100011) with `MEM_HS`=1 and `mem_ready` held 1 → states 0,1,2,3,4; `instr_done` in cycle 5; `retired`=1.
- sw with `MEM_HS`=1, `mem_ready` low for 3 cycles in MEM_WRITE → `mem_write`=1 and `iord`=1 held for 4 cycles, then FETCH.
- `MEM_HS`=0, `MEM_LAT`=3, lw → FETCH lasts 3 cycles and MEM_READ lasts 3 cycles; `ir_write` pulses only in the 3rd FETCH cycle; 9 cycles total.
- opcode 000000 with funct 001000 → JR with `pc_source`=11 and `pc_write`=1. Opcode 001000 → ADDI_EX then ADDI_WB with `reg_write`=1 and `reg_dst`=0.
- Opcode 111111: with the macro → `state`=14 and `illegal`=1, held for 20 cycles. Without the macro → FETCH in 3 cycles and `retired` increments.
- Drop `rst_n` during MEM_READ → outputs 0 immediately and `retired`=0; after release the next edge sees FETCH. Also: `CNT_W`=4 with 17 jal instructions → `retired`=1.
